// File: rtl/matrix_key_emulator_if.sv
// Keypad-side and control-side signals of the matrix key emulator.
interface matrix_key_emulator_if;
    logic [3:0] lin_matrix;
    logic [3:0] key_value;
    logic       press_req;
    logic [3:0] col_matrix;
    logic       busy;
    logic       done;
    logic       contact;

    modport master (
        output lin_matrix, key_value, press_req,
        input  col_matrix, busy, done, contact
    );

    modport slave (
        input  lin_matrix, key_value, press_req,
        output col_matrix, busy, done, contact
    );
endinterface

// File: rtl/matrix_key_emulator.sv
// Emulates one bouncing keypad switch on an active-low row/column matrix:
// closed/open bounce pairs, a solid hold, then a release gap before done.
module matrix_key_emulator #(
    parameter int unsigned HOLD_CYCLES    = 64,
    parameter int unsigned RELEASE_CYCLES = 32,
    parameter int unsigned BOUNCE_PAIRS   = 2,
    parameter int unsigned BOUNCE_PERIOD  = 3
) (
    input logic                  clk,
    input logic                  reset,
    matrix_key_emulator_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBounce, StHold, StRelease} state_e;

    localparam logic [15:0] HoldLast   = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] RelLast    = 16'(RELEASE_CYCLES - 1);
    localparam logic [15:0] PairLast   = 16'(2 * BOUNCE_PERIOD - 1);
    localparam logic [15:0] BounceHalf = 16'(BOUNCE_PERIOD);
    localparam logic [3:0]  LastPair   = (BOUNCE_PAIRS == 0) ? 4'd0 : 4'(BOUNCE_PAIRS - 1);
    localparam state_e      FirstPhase = (BOUNCE_PAIRS == 0) ? StHold : StBounce;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  pair_q, pair_d;
    logic [1:0]  row_q, row_d;
    logic [1:0]  col_q, col_d;
    logic        done_q, done_d;
    logic        contact;
    logic [3:0]  col_matrix;

    // Returns {row, column} for a key code.
    function automatic logic [3:0] key_pos(input logic [3:0] code);
        logic [3:0] pos;
        case (code)
            4'd1:    pos = {2'd0, 2'd0};
            4'd2:    pos = {2'd0, 2'd1};
            4'd3:    pos = {2'd0, 2'd2};
            4'd10:   pos = {2'd0, 2'd3};
            4'd4:    pos = {2'd1, 2'd0};
            4'd5:    pos = {2'd1, 2'd1};
            4'd6:    pos = {2'd1, 2'd2};
            4'd11:   pos = {2'd1, 2'd3};
            4'd7:    pos = {2'd2, 2'd0};
            4'd8:    pos = {2'd2, 2'd1};
            4'd9:    pos = {2'd2, 2'd2};
            4'd12:   pos = {2'd2, 2'd3};
            4'd15:   pos = {2'd3, 2'd0};
            4'd13:   pos = {2'd3, 2'd2};
            4'd14:   pos = {2'd3, 2'd3};
            default: pos = {2'd3, 2'd1};
        endcase
        return pos;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pair_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pair_q  <= pair_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pair_d  = pair_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.press_req) begin
                    {row_d, col_d} = key_pos(bus.key_value);
                    cnt_d   = '0;
                    pair_d  = '0;
                    state_d = FirstPhase;
                end
            end
            StBounce: begin
                // One pair spans 2*BOUNCE_PERIOD counts: closed half first, then open half.
                if (cnt_q == PairLast) begin
                    cnt_d = '0;
                    if (pair_q == LastPair) begin
                        pair_d  = '0;
                        state_d = StHold;
                    end else begin
                        pair_d = pair_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    cnt_d   = '0;
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRelease: begin
                if (cnt_q == RelLast) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        contact = 1'b0;
        case (state_q)
            StBounce: contact = (cnt_q < BounceHalf);
            StHold:   contact = 1'b1;
            default:  contact = 1'b0;
        endcase
        // Only the latched row is looked at, so at most one column is pulled low.
        col_matrix = 4'b1111;
        if (contact && !bus.lin_matrix[row_q]) begin
            col_matrix[col_q] = 1'b0;
        end
    end

    assign bus.contact    = contact;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = done_q;
    assign bus.col_matrix = col_matrix;

endmodule

// File: tb/tb_matrix_key_emulator.sv
// Scoreboard bench: a press model queues per-cycle expected outputs for two
// differently parameterised emulators; a monitor pops and compares each cycle.
module tb_matrix_key_emulator;

    typedef struct packed {
        logic       contact;
        logic       busy;
        logic       done;
        logic [1:0] row;
        logic [1:0] col;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] lin_matrix = 4'b1111;
    logic [3:0] key_value = 4'd0;
    logic       press_req = 1'b0;

    matrix_key_emulator_if bus0 ();
    matrix_key_emulator_if bus1 ();

    assign bus0.lin_matrix = lin_matrix;
    assign bus0.key_value  = key_value;
    assign bus0.press_req  = press_req;
    assign bus1.lin_matrix = lin_matrix;
    assign bus1.key_value  = key_value;
    assign bus1.press_req  = press_req;

    matrix_key_emulator dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    matrix_key_emulator #(
        .HOLD_CYCLES    (4),
        .RELEASE_CYCLES (2),
        .BOUNCE_PAIRS   (0),
        .BOUNCE_PERIOD  (3)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    int unsigned p_hold[2]   = '{64, 4};
    int unsigned p_rel[2]    = '{32, 2};
    int unsigned p_pairs[2]  = '{2, 0};
    int unsigned p_period[2] = '{3, 3};
    int          key_row[16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
    int          key_col[16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 2, 3, 0};

    rec_t        exp_q0[$];
    rec_t        exp_q1[$];
    int unsigned remaining[2] = '{0, 0};
    int          checks = 0;
    int          errors = 0;
    bit          armed = 1'b0;
    int          cyc = 0;
    int          last_done[2] = '{-1, -1};

    task automatic push_rec(input int k, input rec_t r);
        if (k == 0) exp_q0.push_back(r);
        else        exp_q1.push_back(r);
    endtask

    // Expected waveform of one whole press, built straight from the phase lengths.
    task automatic plan(input int k, input logic [3:0] key);
        rec_t r;
        r.busy = 1'b1;
        r.done = 1'b0;
        r.row  = 2'(key_row[key]);
        r.col  = 2'(key_col[key]);
        for (int p = 0; p < int'(p_pairs[k]); p++) begin
            r.contact = 1'b1;
            for (int i = 0; i < int'(p_period[k]); i++) push_rec(k, r);
            r.contact = 1'b0;
            for (int i = 0; i < int'(p_period[k]); i++) push_rec(k, r);
        end
        r.contact = 1'b1;
        for (int i = 0; i < int'(p_hold[k]); i++) push_rec(k, r);
        r.contact = 1'b0;
        for (int i = 0; i < int'(p_rel[k]); i++) push_rec(k, r);
        r.busy = 1'b0;
        r.done = 1'b1;
        push_rec(k, r);
        remaining[k] = 2 * p_period[k] * p_pairs[k] + p_hold[k] + p_rel[k];
    endtask

    task automatic check(input string name, input int k, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    // Press model: decides acceptance at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (reset) begin
                    if (k == 0) exp_q0.delete();
                    else        exp_q1.delete();
                    remaining[k] = 0;
                end else if (remaining[k] != 0) begin
                    remaining[k]--;
                end else if (press_req) begin
                    plan(k, key_value);
                end
            end
            if (reset) armed = 1'b1;
        end
    end

    // Monitor: one expected record per cycle, idle when nothing is queued.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int k = 0; k < 2; k++) begin
                    rec_t       e;
                    logic [3:0] exp_col;
                    logic [3:0] one_hot;
                    logic       a_contact, a_busy, a_done;
                    logic [3:0] a_col;
                    e = '0;
                    if (k == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
                    if (k == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
                    one_hot = 4'b0001 << e.col;
                    exp_col = (e.contact && !lin_matrix[e.row]) ? ~one_hot : 4'b1111;
                    a_contact = (k == 0) ? bus0.contact    : bus1.contact;
                    a_busy    = (k == 0) ? bus0.busy       : bus1.busy;
                    a_done    = (k == 0) ? bus0.done       : bus1.done;
                    a_col     = (k == 0) ? bus0.col_matrix : bus1.col_matrix;
                    if (a_done === 1'b1) last_done[k] = cyc;
                    check("contact", k, {3'b0, a_contact}, {3'b0, e.contact});
                    check("busy", k, {3'b0, a_busy}, {3'b0, e.busy});
                    check("done", k, {3'b0, a_done}, {3'b0, e.done});
                    check("col_matrix", k, a_col, exp_col);
                end
            end
        end
    end

    function automatic logic [3:0] rand_lin();
        logic [3:0] one_hot;
        if ($urandom_range(3, 0) == 0) return 4'($urandom);
        one_hot = 4'b0001 << $urandom_range(3, 0);
        return ~one_hot;
    endfunction

    task automatic step(input bit pr, input logic [3:0] kv, input bit rst);
        @(posedge clk);
        #1;
        press_req  = pr;
        key_value  = kv;
        reset      = rst;
        lin_matrix = rand_lin();
    endtask

    initial begin
        int accept_cyc;
        repeat (3) step(1'b0, 4'd0, 1'b1);
        repeat (2) step(1'b0, 4'd0, 1'b0);

        // Single press of key 5; check total latency on both instances.
        step(1'b1, 4'd5, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        accept_cyc = cyc;
        repeat (120) step(1'b0, 4'd0, 1'b0);
        check("latency_default", 0, 4'(last_done[0] - accept_cyc), 4'(108));
        checks++;
        if (last_done[0] - accept_cyc != 108) begin
            errors++;
            $display("FAIL latency_default_full: got %0d expected 108",
                     last_done[0] - accept_cyc);
        end
        checks++;
        if (last_done[1] - accept_cyc != 6) begin
            errors++;
            $display("FAIL latency_short: got %0d expected 6", last_done[1] - accept_cyc);
        end

        // press_req held high: back-to-back sequences.
        repeat (350) step(1'b1, 4'd0, 1'b0);
        repeat (120) step(1'b0, 4'd0, 1'b0);

        // Second press while busy must be ignored.
        step(1'b1, 4'd12, 1'b0);
        repeat (20) step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd9, 1'b0);
        repeat (120) step(1'b0, 4'd0, 1'b0);

        // Reset while the default instance is in HOLD.
        step(1'b1, 4'd3, 1'b0);
        repeat (40) step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b1);
        repeat (5) step(1'b0, 4'd0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(5, 0) == 0, 4'($urandom), $urandom_range(299, 0) == 0);
        end
        repeat (200) step(1'b0, 4'd0, 1'b0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_key_emulator.md
MATRIX_KEY_EMULATOR -- requirements
Module: matrix_key_emulator

Interface
REQ-001 Parameter HOLD_CYCLES, default 64: cycles the contact stays solidly closed after bounce; legal range 1..65535.
REQ-002 Parameter RELEASE_CYCLES, default 32: cycles the contact stays open before completion; legal range 1..65535.
REQ-003 Parameter BOUNCE_PAIRS, default 2: number of closed/open bounce pairs before hold; legal range 0..15.
REQ-004 Parameter BOUNCE_PERIOD, default 3: cycles per bounce half-pair; legal range 1..255.
REQ-005 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-006 Port reset  input  1: synchronous, active-high reset.
REQ-007 Port lin_matrix  input  4: row drive from the keypad scanner; active-low, one bit per row.
REQ-008 Port key_value  input  4: key code to press; sampled only when a press is accepted.
REQ-009 Port press_req  input  1: request to perform one complete press/release sequence.
REQ-010 Port col_matrix  output  4: emulated column lines; active-low; idle value 4'b1111.
REQ-011 Port busy  output  1: high while a sequence is in progress.
REQ-012 Port done  output  1: one-cycle pulse when a sequence completes.
REQ-013 Port contact  output  1: current emulated switch state; 1 = closed.

Function
REQ-014 Key map (code -> row, low column index): 1->(0,0), 2->(0,1), 3->(0,2), 10->(0,3); 4->(1,0), 5->(1,1), 6->(1,2), 11->(1,3); 7->(2,0), 8->(2,1), 9->(2,2), 12->(2,3); 15->(3,0), 0->(3,1), 13->(3,2), 14->(3,3).
REQ-015 Row and column are latched from key_value on acceptance and held constant until the next acceptance.
REQ-016 col_matrix is combinational: when contact=1 and lin_matrix[latched_row]=0, the latched column bit is 0 and all other bits are 1; otherwise col_matrix=4'b1111.
REQ-017 If multiple lin_matrix bits are low, only the latched row is evaluated; at most one col_matrix bit is ever 0.
REQ-018 FSM states are IDLE, BOUNCE, HOLD and RELEASE; busy=1 in every state except IDLE.
REQ-019 IDLE: press_req=1 is accepted at edge T; key_value is latched; contact=1 from T+1; next state is BOUNCE, or HOLD if BOUNCE_PAIRS=0.
REQ-020 BOUNCE: contact closed for BOUNCE_PERIOD cycles, then open for BOUNCE_PERIOD cycles, repeated BOUNCE_PAIRS times; then HOLD with contact=1.
REQ-021 HOLD: contact=1 for exactly HOLD_CYCLES cycles; then RELEASE with contact=0.
REQ-022 RELEASE: contact=0 for exactly RELEASE_CYCLES cycles; then IDLE with done=1 for exactly that first IDLE cycle.
REQ-023 press_req while busy=1 is ignored and not queued; key_value changes while busy have no effect.
REQ-024 press_req=1 on the cycle done=1 (state IDLE) is accepted normally, giving back-to-back sequences.
REQ-025 Holding press_req high continuously gives repeated sequences, one per completion.
REQ-026 Phase and bounce counters are 16 bits and 4 bits, reset at each phase entry, and never wrap within a legal parameter range.
REQ-027 Total sequence length from acceptance to done is 2*BOUNCE_PERIOD*BOUNCE_PAIRS + HOLD_CYCLES + RELEASE_CYCLES cycles.
REQ-028 Defaults satisfy the scanner requirement: HOLD_CYCLES exceeds the scanner's 26-cycle debounce window, and RELEASE_CYCLES exceeds one full 4-row scan.

Reset
REQ-029 When reset=1 at an edge: state=IDLE, contact=0, busy=0, done=0, latched row=0, latched column=0, and all counters=0.
REQ-030 Reset mid-sequence aborts it: col_matrix=4'b1111 from the following cycle, and no done pulse is produced.
REQ-031 press_req is ignored in any cycle where reset=1.

Verification
REQ-032 Defaults; key_value=5 and press_req pulsed at T -> busy from T+1; after bounce, col_matrix=4'b1101 only while lin_matrix=4'b1101; done at T+1+12+64+32.
REQ-033 BOUNCE_PAIRS=0, HOLD_CYCLES=4, RELEASE_CYCLES=2, key_value=14 with lin_matrix held at 4'b0111 -> col_matrix=4'b0111 for exactly 4 cycles, then 4'b1111; done 6 cycles after contact rises.
REQ-034 Second press_req with key_value=9 while busy -> ignored; col_matrix never shows column 2; exactly one done pulse.
REQ-035 press_req held high with key_value=0 -> consecutive sequences; the cycle after each done, contact=1 again.
REQ-036 reset asserted in HOLD -> next cycle contact=0, busy=0, col_matrix=4'b1111, and no done pulse.
REQ-037 Connected to the keypad scanner, press keys 1, 0, 15, 12 in turn -> the scanner reports values 1, 0, 15, 12, each with exactly one valid pulse.
